// File: rtl/mac_sched.sv
// mac_sched: round-robin scheduler that shares one MAC engine among three
// requesters. A granted requester streams N_TERMS operand pairs to the
// engine and the accumulated result is returned to it with a done pulse.
// A job that is still unfinished TIMEOUT cycles after it starts is aborted,
// and the sticky err flag is set.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req[2:0]            per-requester job request (held until done)
//   a0..b2[15:0]        per-requester operand pairs
//   gnt[2:0]            one-hot grant of the active job
//   op_take             granted requester advances to its next operand pair
//   mac_a, mac_b        operands of the granted requester (0 when idle)
//   mac_cs              one-cycle job start to the engine
//   mac_sync            engine sampled mac_a/mac_b
//   mac_rdy             engine idle/finished
//   mac_out[15:0]       engine accumulated result
//   result[15:0]        result of the last completed job
//   done[2:0]           one-cycle completion pulse to the owner
//   busy                scheduler not idle
//   err                 sticky timeout flag
module mac_sched #(
  parameter int N_TERMS = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic [15:0] a2,
  input  logic [15:0] b2,
  output logic [2:0]  gnt,
  output logic        op_take,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic        mac_cs,
  input  logic        mac_sync,
  input  logic        mac_rdy,
  input  logic [15:0] mac_out,
  output logic [15:0] result,
  output logic [2:0]  done,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(N_TERMS + 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_BUSY, RUN, WAIT_DONE, DONE, ABORT
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      ptr;
  logic [CW-1:0]   term_cnt;
  logic [TW-1:0]   to_cnt;
  logic [2:0]      pick;
  logic            to_hit;
  logic            last_term;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int unsigned i);
    int unsigned s;
    s = (32'(p) + i) % 3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] ptr_after(input logic [2:0] g);
    if (g[0])      return 2'd1;
    else if (g[1]) return 2'd2;
    else           return 2'd0;
  endfunction

  // First requesting index found starting at ptr, wrapping mod 3.
  always_comb begin
    pick = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (pick == '0 && req[rr_idx(ptr, i)])
        pick[rr_idx(ptr, i)] = 1'b1;
    end
  end

  // to_cnt holds the number of active cycles already spent on this job,
  // so the TIMEOUT-th active cycle is the one that diverts to ABORT.
  assign to_hit    = (to_cnt == TW'(TIMEOUT - 1));
  assign last_term = (term_cnt == CW'(N_TERMS - 1));

  always_comb begin
    state_nxt = state;
    mac_cs    = 1'b0;
    op_take   = 1'b0;
    unique case (state)
      IDLE:      if (|req) state_nxt = START;
      START: begin
        mac_cs    = 1'b1;
        state_nxt = to_hit ? ABORT : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (to_hit)        state_nxt = ABORT;
        else if (!mac_rdy) state_nxt = RUN;
      end
      RUN: begin
        op_take = mac_sync;
        if (to_hit)                      state_nxt = ABORT;
        else if (mac_sync && last_term)  state_nxt = WAIT_DONE;
      end
      // Completion takes priority over a coincident timeout.
      WAIT_DONE: begin
        if (mac_rdy)     state_nxt = DONE;
        else if (to_hit) state_nxt = ABORT;
      end
      DONE, ABORT:       state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      term_cnt <= '0;
      to_cnt   <= '0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          term_cnt <= '0;
          to_cnt   <= '0;
          if (|req) gnt <= pick;
        end
        START: begin
          term_cnt <= '0;
          to_cnt   <= TW'(1);
        end
        WAIT_BUSY: to_cnt <= to_cnt + TW'(1);
        RUN: begin
          to_cnt <= to_cnt + TW'(1);
          if (mac_sync) term_cnt <= term_cnt + CW'(1);
        end
        WAIT_DONE: begin
          to_cnt <= to_cnt + TW'(1);
          if (mac_rdy) result <= mac_out;
        end
        DONE: begin
          gnt <= '0;
          ptr <= ptr_after(gnt);
        end
        ABORT: begin
          err <= 1'b1;
          gnt <= '0;
          ptr <= ptr_after(gnt);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    if (gnt[0]) begin
      mac_a = a0;
      mac_b = b0;
    end else if (gnt[1]) begin
      mac_a = a1;
      mac_b = b1;
    end else if (gnt[2]) begin
      mac_a = a2;
      mac_b = b2;
    end
  end

  assign done = (state == DONE) ? gnt : '0;
  assign busy = (state != IDLE);

endmodule
